// File: rtl/shift_pipe_pkg.sv
// Shared types for the pipelined barrel shifter (shift_pipe).
package shift_pipe_pkg;

    typedef enum logic [1:0] {
        OP_LSL = 2'b00,
        OP_LSR = 2'b01,
        OP_ASR = 2'b10,
        OP_ROR = 2'b11
    } shift_op_e;

    // Number of pipeline slots needed for nstage mux stages grouped by reg_every.
    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/shift_pipe_stage.sv
// One combinational mux stage of the barrel shifter: shifts by DIST when en is set.
// Rotate support is only built when SHIFT_PIPE_ROR_EN is defined; otherwise ROR
// operands have already been zeroed at accept, so passing data through keeps them zero.
module shift_stage
    import shift_pipe_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] data,
    input  logic             en,
    input  shift_op_e        op,
    input  logic             fill,
    output logic [WIDTH-1:0] shifted
);

    // Select the shifted or unshifted operand according to op and the enable bit.
    always_comb begin
        shifted = data;
        if (en) begin
            case (op)
                OP_LSL: shifted = data << DIST;
                OP_LSR: shifted = data >> DIST;
                OP_ASR: shifted = {{DIST{fill}}, data[WIDTH-1:DIST]};
                OP_ROR: begin
`ifdef SHIFT_PIPE_ROR_EN
                    shifted = {data[DIST-1:0], data[WIDTH-1:DIST]};
`else
                    shifted = data;
`endif
                end
                default: shifted = data;
            endcase
        end
    end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter with valid/ready handshakes and a tag sideband.
// Optional feature macro: SHIFT_PIPE_ROR_EN enables rotate-right for op 11;
// without it op 11 still flows through the pipe but returns zero data.
module shift_pipe
    import shift_pipe_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int TAG_W     = 4,
    parameter int REG_EVERY = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [$clog2(WIDTH)-1:0]   in_shamt,
    input  logic [1:0]                 in_op,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [TAG_W-1:0]           out_tag,
    output logic                       busy
);

    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int NSTAGE  = SHAMT_W;
    localparam int LAT     = ceil_div(NSTAGE, REG_EVERY);

    typedef struct packed {
        logic               valid;
        logic [WIDTH-1:0]   data;
        logic [SHAMT_W-1:0] shamt;
        shift_op_e          op;
        logic               fill;
        logic [TAG_W-1:0]   tag;
    } slot_t;

    slot_t            slots   [LAT];
    slot_t            nxt     [LAT];
    logic [WIDTH-1:0] grp_out [LAT];
    logic [WIDTH-1:0] in_data_eff;
    shift_op_e        in_op_e;
    logic             adv;

    assign in_op_e = shift_op_e'(in_op);

`ifdef SHIFT_PIPE_ROR_EN
    assign in_data_eff = in_data;
`else
    assign in_data_eff = (in_op_e == OP_ROR) ? '0 : in_data;
`endif

    // Mux stages; the first stage of each group reads the previous slot (or the input).
    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        localparam int G = k / REG_EVERY;
        logic [WIDTH-1:0] din;
        logic [WIDTH-1:0] dout;
        logic             en;
        logic             fill;
        shift_op_e        op;

        if (G == 0) begin : g_ctl_in
            assign en   = in_shamt[k];
            assign op   = in_op_e;
            assign fill = in_data[WIDTH-1];
        end else begin : g_ctl_slot
            assign en   = slots[G-1].shamt[k];
            assign op   = slots[G-1].op;
            assign fill = slots[G-1].fill;
        end

        if (k % REG_EVERY == 0) begin : g_head
            if (G == 0) begin : g_from_in
                assign din = in_data_eff;
            end else begin : g_from_slot
                assign din = slots[G-1].data;
            end
        end else begin : g_chain
            assign din = g_stage[k-1].dout;
        end

        shift_stage #(
            .WIDTH (WIDTH),
            .DIST  (1 << k)
        ) u_stage (
            .data    (din),
            .en      (en),
            .op      (op),
            .fill    (fill),
            .shifted (dout)
        );

        if ((k == NSTAGE - 1) || ((k + 1) % REG_EVERY == 0)) begin : g_tap
            assign grp_out[G] = dout;
        end
    end

    // Next contents of every slot when the pipe advances.
    always_comb begin
        nxt[0].valid = in_valid;
        nxt[0].data  = grp_out[0];
        nxt[0].shamt = in_shamt;
        nxt[0].op    = in_op_e;
        nxt[0].fill  = in_data[WIDTH-1];
        nxt[0].tag   = in_tag;
        for (int g = 1; g < LAT; g++) begin
            nxt[g]      = slots[g-1];
            nxt[g].data = grp_out[g];
        end
    end

    // Pipeline registers: all slots move together or all hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int g = 0; g < LAT; g++) begin
                slots[g] <= '0;
            end
        end else if (adv) begin
            for (int g = 0; g < LAT; g++) begin
                slots[g] <= nxt[g];
            end
        end
    end

    // Occupancy flag: any slot holding a live operation.
    always_comb begin
        busy = 1'b0;
        for (int g = 0; g < LAT; g++) begin
            busy = busy | slots[g].valid;
        end
    end

    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign out_valid = slots[LAT-1].valid;
    assign out_data  = slots[LAT-1].data;
    assign out_tag   = slots[LAT-1].tag;

    // Control fields of the final slot have no consumer once the data is complete.
    logic unused_tail;
    assign unused_tail = ^{slots[LAT-1].shamt, slots[LAT-1].op, slots[LAT-1].fill};

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe (default parameters, LAT = 3).
module tb_shift_pipe;

    localparam int WIDTH = 64;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [5:0]       in_shamt;
    logic [1:0]       in_op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    shift_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [63:0] d, input logic [5:0] s,
                                          input logic [1:0] op);
        case (op)
            2'b00:   return d << s;
            2'b01:   return d >> s;
            2'b10:   return 64'($signed(d) >>> s);
            default: begin
`ifdef SHIFT_PIPE_ROR_EN
                return (d >> s) | (d << (7'd64 - {1'b0, s}));
`else
                return '0;
`endif
            end
        endcase
    endfunction

    // Scoreboard and output monitor, sampled on the falling edge.
    logic [WIDTH+TAG_W-1:0] sb [$];
    logic [WIDTH+TAG_W-1:0] e;
    int   cyc      = 0;
    int   n_out    = 0;
    int   last_out = -1;
    bit   gap_mode = 0;
    bit   held_v   = 0;
    logic [WIDTH-1:0] held_d;
    logic [TAG_W-1:0] held_t;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            sb.delete();
            held_v = 0;
        end else begin
            if (held_v) begin
                chk("hold_data", out_data, held_d);
                chk("hold_tag", out_tag, held_t);
            end
            held_v = out_valid && !out_ready;
            held_d = out_data;
            held_t = out_tag;
            if (out_valid && out_ready) begin
                n_out++;
                chk("sb_nonempty", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("out_data", out_data, e[WIDTH+TAG_W-1:TAG_W]);
                    chk("out_tag", out_tag, e[TAG_W-1:0]);
                end
                if (gap_mode && last_out >= 0) chk("bubble_gap", cyc - last_out, 2);
                last_out = cyc;
            end
            if (in_valid && in_ready) sb.push_back({model(in_data, in_shamt, in_op), in_tag});
        end
    end

    task automatic drive(input logic [63:0] d, input logic [5:0] s, input logic [1:0] op,
                         input logic [3:0] tag);
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = s;
        in_op    = op;
        in_tag   = tag;
    endtask

    task automatic wait_acc();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", n < 50, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_sb", sb.size(), 0);
        chk("drain_busy", busy, 0);
    endtask

    // Single directed op: checks latency and the result against a fixed value.
    task automatic run_one(input string tag, input logic [63:0] d, input logic [5:0] s,
                           input logic [1:0] op, input logic [3:0] t, input logic [63:0] exp);
        int lat = 1;
        out_ready = 1'b1;
        drive(d, s, op, t);
        wait_acc();
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, 3);
        chk({tag, "_data"}, out_data, exp);
        chk({tag, "_tag"}, out_tag, t);
        drain();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ti;
        int n0;
        int seen;
        logic [63:0] ror_exp;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_op     = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_tag", out_tag, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_one("lsl63", 64'h1, 6'd63, 2'b00, 4'd3, 64'h8000_0000_0000_0000);
        run_one("asr4", 64'h8000_0000_0000_00F0, 6'd4, 2'b10, 4'd5, 64'hF800_0000_0000_000F);
        run_one("lsr4", 64'h8000_0000_0000_00F0, 6'd4, 2'b01, 4'd6, 64'h0800_0000_0000_000F);
`ifdef SHIFT_PIPE_ROR_EN
        ror_exp = 64'h8000_0000_0000_0000;
`else
        ror_exp = 64'h0;
`endif
        run_one("ror1", 64'h1, 6'd1, 2'b11, 4'd7, ror_exp);
        run_one("asr_pos", 64'h7000_0000_0000_0000, 6'd60, 2'b10, 4'd8, 64'h7);

        // Random traffic with random backpressure.
        repeat (300) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = {$urandom, $urandom};
            in_shamt  = 6'($urandom_range(0, 63));
            in_op     = 2'($urandom_range(0, 3));
            in_tag    = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        // Back-to-back tags 0..7, consumer stalls for five cycles starting at cycle 4.
        n0 = n_out;
        ti = 0;
        for (int c = 0; c < 60 && (ti < 8 || busy); c++) begin
            in_valid  = (ti < 8);
            in_data   = {$urandom, $urandom};
            in_shamt  = 6'($urandom_range(0, 63));
            in_op     = 2'($urandom_range(0, 3));
            in_tag    = ti[3:0];
            out_ready = !(c >= 4 && c < 9);
            @(negedge clk);
            if (c >= 4 && c < 9) chk("bp_in_ready", in_ready, 0);
            if (in_valid && in_ready) ti++;
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();
        chk("bp_count", n_out - n0, 8);

        // Reset with three operations in flight.
        for (int c = 0; c < 3; c++) begin
            drive({$urandom, $urandom}, 6'($urandom_range(0, 63)), 2'b00, 4'(c));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("post_rst_quiet", seen, 0);
        @(posedge clk);
        #1;

        // Zero shift with a bubble between every operation.
        gap_mode = 1;
        last_out = -1;
        n0 = n_out;
        for (int i = 0; i < 20; i++) begin
            in_valid  = (i % 2 == 0);
            in_data   = {$urandom, $urandom};
            in_shamt  = 6'd0;
            in_op     = 2'($urandom_range(0, 3));
            in_tag    = 4'(i);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        drain();
        gap_mode = 0;
        chk("bubble_count", n_out - n0, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
